// File: rtl/plru_state_table_pkg.sv
// Shared cache geometry constants and the PLRU table FSM encoding.
// The cache datapath and the PLRU state table both use these definitions.
package plru_state_table_pkg;

   localparam int PLRU_WAYS      = 4;
   localparam int PLRU_LOG_WAYS  = 2;
   localparam int PLRU_LINES     = 16;
   localparam int PLRU_LOG_LINES = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } plru_state_e;

   // Follow the in-order tree from the root to the way it currently points at.
   function automatic logic [PLRU_LOG_WAYS-1:0] plru_victim(input logic [PLRU_WAYS-2:0] tree);
      int lo;
      int span;
      lo   = 0;
      span = PLRU_WAYS;
      for (int l = 0; l < PLRU_LOG_WAYS; l++) begin
         span = span / 2;
         lo   = tree[lo + span - 1] ? (lo + span) : lo;
      end
      return PLRU_LOG_WAYS'(lo);
   endfunction

endpackage

// File: rtl/plru_state_table_next.sv
// Combinational next-tree logic: rewrites every node on the path to the
// accessed way so that it points away from that way.
module plru_next
   import plru_state_table_pkg::*;
#(
   parameter int number_of_sets        = PLRU_WAYS,
   parameter int log_of_number_of_sets = PLRU_LOG_WAYS
) (
   input  logic [number_of_sets-2:0]        cur_tree,
   input  logic [log_of_number_of_sets-1:0] way,
   output logic [number_of_sets-2:0]        new_tree
);

   localparam int TW = number_of_sets - 1;

   // Level l covers a span of number_of_sets>>l ways; its node is at lo+half-1.
   always_comb begin
      int                lo;
      int                half;
      logic              upper;
      logic [TW-1:0]     mask;
      lo       = 0;
      half     = 0;
      upper    = 1'b0;
      mask     = '0;
      new_tree = cur_tree;
      for (int l = 0; l < log_of_number_of_sets; l++) begin
         half     = number_of_sets >> (l + 1);
         lo       = (int'(way) >> (log_of_number_of_sets - l)) << (log_of_number_of_sets - l);
         upper    = (int'(way) >= (lo + half));
         mask     = TW'(1'b1) << (lo + half - 1);
         new_tree = upper ? (new_tree & ~mask) : (new_tree | mask);
      end
   end

endmodule

// File: rtl/plru_state_table.sv
// Per-index pseudo-LRU tree storage with one-cycle reads, write-first bypass
// on same-index read/update, and a one-entry-per-cycle flush sweep.
module plru_state_table
   import plru_state_table_pkg::*;
#(
   parameter int number_of_sets         = PLRU_WAYS,
   parameter int log_of_number_of_sets  = PLRU_LOG_WAYS,
   parameter int number_of_lines        = PLRU_LINES,
   parameter int log_of_number_of_lines = PLRU_LOG_LINES
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              rd_en,
   input  logic [log_of_number_of_lines-1:0] rd_index,
   output logic [number_of_sets-2:0]         lru_out,
   output logic                              rd_valid,
   input  logic                              upd_en,
   input  logic [log_of_number_of_lines-1:0] upd_index,
   input  logic [log_of_number_of_sets-1:0]  upd_way,
   input  logic                              flush_req,
   output logic                              busy
);

   localparam int LW = log_of_number_of_lines;
   localparam logic [LW-1:0] SWEEP_LAST = LW'(number_of_lines - 1);
   localparam logic [LW-1:0] SWEEP_ONE  = LW'(1'b1);

   logic [number_of_sets-2:0] table_r [number_of_lines];
   plru_state_e               state_r;
   logic [LW-1:0]             sweep_r;
   logic                      busy_r;
   logic                      rd_valid_r;
   logic [number_of_sets-2:0] lru_r;

   logic [number_of_sets-2:0] next_tree_s;
   logic                      idle_s;
   logic                      upd_accept_s;
   logic                      rd_accept_s;
   logic                      bypass_s;
   logic [number_of_sets-2:0] rd_data_s;

   plru_next #(
      .number_of_sets        (number_of_sets),
      .log_of_number_of_sets (log_of_number_of_sets)
   ) u_next (
      .cur_tree (table_r[upd_index]),
      .way      (upd_way),
      .new_tree (next_tree_s)
   );

   // Request qualification; a flush request wins over a coincident update.
   always_comb begin
      idle_s       = (state_r == ST_IDLE);
      upd_accept_s = idle_s && upd_en && !flush_req;
      rd_accept_s  = idle_s && rd_en;
      bypass_s     = upd_accept_s && (upd_index == rd_index);
      rd_data_s    = bypass_s ? next_tree_s : table_r[rd_index];
   end

   // Table storage: sweep clear during flush, otherwise accepted updates.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < number_of_lines; i++) begin
            table_r[i] <= '0;
         end
      end else if (state_r == ST_FLUSH) begin
         table_r[sweep_r] <= '0;
      end else if (upd_accept_s) begin
         table_r[upd_index] <= next_tree_s;
      end
   end

   // Control FSM with registered read response and busy flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         sweep_r    <= '0;
         busy_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         lru_r      <= '0;
      end else begin
         rd_valid_r <= rd_accept_s;
         if (rd_accept_s) begin
            lru_r <= rd_data_s;
         end
         case (state_r)
            ST_IDLE: begin
               sweep_r <= '0;
               if (flush_req) begin
                  state_r <= ST_FLUSH;
                  busy_r  <= 1'b1;
               end
            end
            ST_FLUSH: begin
               if (sweep_r == SWEEP_LAST) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  sweep_r <= '0;
               end else begin
                  sweep_r <= sweep_r + SWEEP_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               sweep_r <= '0;
            end
         endcase
      end
   end

   assign lru_out  = lru_r;
   assign rd_valid = rd_valid_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_plru_state_table.sv
// Directed bench for plru_state_table (4 ways, 16 lines): vector table for the
// read/update/bypass behaviour plus hand sequences for flush and reset abort.
module tb_plru_state_table;
   import plru_state_table_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       rd_en;
   logic [3:0] rd_index;
   logic [2:0] lru_out;
   logic       rd_valid;
   logic       upd_en;
   logic [3:0] upd_index;
   logic [1:0] upd_way;
   logic       flush_req;
   logic       busy;

   int n_checks;
   int n_fail;
   int busy_cnt;

   typedef struct packed {
      logic       rd_en;
      logic [3:0] rd_index;
      logic       upd_en;
      logic [3:0] upd_index;
      logic [1:0] upd_way;
      logic       exp_valid;
      logic [2:0] exp_lru;
   } vec_t;

   vec_t vecs [12];

   plru_state_table dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_en     (rd_en),
      .rd_index  (rd_index),
      .lru_out   (lru_out),
      .rd_valid  (rd_valid),
      .upd_en    (upd_en),
      .upd_index (upd_index),
      .upd_way   (upd_way),
      .flush_req (flush_req),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic re, input logic [3:0] ri, input logic ue,
                        input logic [3:0] ui, input logic [1:0] uw, input logic fl);
      @(negedge clk);
      rd_en     = re;
      rd_index  = ri;
      upd_en    = ue;
      upd_index = ui;
      upd_way   = uw;
      flush_req = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic read_expect(input logic [3:0] idx, input logic [2:0] exp, input string name);
      cycle(1'b1, idx, 1'b0, 4'd0, 2'd0, 1'b0);
      check({name, " valid"}, 32'(rd_valid), 32'd1);
      check({name, " lru"}, 32'(lru_out), 32'(exp));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      rd_en     = 1'b0;
      rd_index  = 4'd0;
      upd_en    = 1'b0;
      upd_index = 4'd0;
      upd_way   = 2'd0;
      flush_req = 1'b0;

      //            rd    ridx   upd   uidx   way   v     lru
      vecs[0]  = '{1'b1, 4'd5, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000};
      vecs[1]  = '{1'b0, 4'd0, 1'b1, 4'd3, 2'd0, 1'b0, 3'b000};
      vecs[2]  = '{1'b1, 4'd3, 1'b0, 4'd0, 2'd0, 1'b1, 3'b011};
      vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd3, 2'd2, 1'b0, 3'b011};
      vecs[4]  = '{1'b1, 4'd3, 1'b0, 4'd0, 2'd0, 1'b1, 3'b101};
      vecs[5]  = '{1'b0, 4'd0, 1'b1, 4'd7, 2'd0, 1'b0, 3'b101};
      vecs[6]  = '{1'b1, 4'd7, 1'b1, 4'd7, 2'd3, 1'b1, 3'b001};
      vecs[7]  = '{1'b1, 4'd7, 1'b0, 4'd0, 2'd0, 1'b1, 3'b001};
      vecs[8]  = '{1'b1, 4'd3, 1'b1, 4'd5, 2'd1, 1'b1, 3'b101};
      vecs[9]  = '{1'b1, 4'd5, 1'b0, 4'd0, 2'd0, 1'b1, 3'b010};
      vecs[10] = '{1'b1, 4'd0, 1'b1, 4'd5, 2'd3, 1'b1, 3'b000};
      vecs[11] = '{1'b1, 4'd5, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000};

      repeat (3) @(posedge clk);
      #1;
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset lru_out", 32'(lru_out), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].rd_en, vecs[i].rd_index, vecs[i].upd_en,
               vecs[i].upd_index, vecs[i].upd_way, 1'b0);
         check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d lru_out", i), 32'(lru_out), 32'(vecs[i].exp_lru));
         check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      end

      read_expect(4'd3, 3'b101, "idx3 after way2");
      check("idx3 victim", 32'(plru_victim(lru_out)), 32'd1);

      // Fill every index with a way-0 access so nothing reads as zero.
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 4'd0, 1'b1, 4'(i), 2'd0, 1'b0);
      end
      read_expect(4'd3, 3'b111, "idx3 filled");
      read_expect(4'd5, 3'b011, "idx5 filled");

      // Flush with a coincident update (dropped) and read (served, pre-flush).
      cycle(1'b1, 4'd7, 1'b1, 4'd0, 2'd3, 1'b1);
      check("flush-cycle rd_valid", 32'(rd_valid), 32'd1);
      check("flush-cycle lru_out", 32'(lru_out), 32'b011);
      check("flush busy start", 32'(busy), 32'd1);
      busy_cnt = 1;
      for (int k = 0; k < 40; k++) begin
         cycle(1'b1, 4'(k), 1'b1, 4'd2, 2'd0, 1'b1);
         if (busy) begin
            busy_cnt++;
            check("rd_valid while busy", 32'(rd_valid), 32'd0);
         end else begin
            break;
         end
      end
      check("busy cycle count", 32'(busy_cnt), 32'd16);
      check("rd_valid at busy end", 32'(rd_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         read_expect(4'(i), 3'b000, $sformatf("post-flush idx%0d", i));
      end
      check("busy after flush", 32'(busy), 32'd0);

      // Reset asserted mid-sweep aborts the flush and clears everything.
      cycle(1'b0, 4'd0, 1'b1, 4'd8, 2'd0, 1'b0);
      cycle(1'b0, 4'd0, 1'b1, 4'd9, 2'd0, 1'b0);
      cycle(1'b0, 4'd0, 1'b1, 4'd12, 2'd0, 1'b0);
      cycle(1'b1, 4'd9, 1'b0, 4'd0, 2'd0, 1'b1);
      check("pre-abort lru_out", 32'(lru_out), 32'b011);
      repeat (8) cycle(1'b0, 4'd0, 1'b0, 4'd0, 2'd0, 1'b0);
      check("busy before abort", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort rd_valid", 32'(rd_valid), 32'd0);
      check("abort lru_out", 32'(lru_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         read_expect(4'(i), 3'b000, $sformatf("post-abort idx%0d", i));
         check("busy after abort", 32'(busy), 32'd0);
      end
      cycle(1'b0, 4'd0, 1'b1, 4'd4, 2'd2, 1'b0);
      read_expect(4'd4, 3'b100, "idx4 after abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
